// File: rtl/service_2_countdown_if.sv
// Bundle between the time-set service, the countdown stage
// and the display block.
interface service_2_countdown_if;
  logic        finish1;
  logic [15:0] num;
  logic        push_c;
  logic [15:0] time_out;
  logic        running;
  logic        alarm;
  logic        blank;

  modport master (
    output finish1,
    output num,
    output push_c,
    input  time_out,
    input  running,
    input  alarm,
    input  blank
  );

  modport slave (
    input  finish1,
    input  num,
    input  push_c,
    output time_out,
    output running,
    output alarm,
    output blank
  );
endinterface

// File: rtl/service_2_countdown.sv
// BCD mm:ss countdown with start/pause, alarm at 00:00.
// SERVICE2_BLINK_EN adds a blinking blank request while expired.
module service_2_countdown #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input logic clk,
  input logic reset,
  service_2_countdown_if.slave bus
);

  if (TICK_DIV < 2 || BLINK_DIV < 1) begin : g_bad_cfg
    $error("service_2_countdown: bad divider");
  end

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_RUN,
    S_PAUSE,
    S_EXPIRED
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          alarm_q, alarm_d;
  logic [15:0]   ld_val;
  logic          tick;

  function automatic logic [15:0] dec_bcd(
    input logic [15:0] v
  );
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // Sec-tens above 5 is not a valid second; clamp on load.
  always_comb begin
    ld_val = bus.num;
    if (bus.num[7:4] > 4'd5) ld_val[7:4] = 4'd5;
  end

  assign tick = (presc_q == P_TOP);

  // Next-state, counter and prescaler; load beats push_c.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    alarm_d = alarm_q;
    if (bus.finish1) begin
      cnt_d   = ld_val;
      presc_d = '0;
      alarm_d = 1'b0;
      state_d = (ld_val == 16'h0000) ? S_IDLE : S_LOADED;
    end else begin
      unique case (state_q)
        S_LOADED: begin
          if (bus.push_c) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (bus.push_c) state_d = S_PAUSE;
          if (tick && cnt_q != 16'h0000) begin
            cnt_d = dec_bcd(cnt_q);
            if (cnt_q == 16'h0001) begin
              state_d = S_EXPIRED;
              alarm_d = 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (bus.push_c) state_d = S_RUN;
        end
        S_EXPIRED: begin
          if (bus.push_c) begin
            state_d = S_IDLE;
            alarm_d = 1'b0;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    running_d = (state_d == S_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'h0000;
      presc_q   <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  assign bus.time_out = cnt_q;
  assign bus.running  = running_q;
  assign bus.alarm    = alarm_q;

`ifdef SERVICE2_BLINK_EN
  localparam int BW =
    (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] B_TOP = BW'(BLINK_DIV - 1);

  logic          blank_q, blank_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  // Blank starts high on expiry, then toggles per period.
  always_comb begin
    blank_d = 1'b0;
    bcnt_d  = '0;
    if (state_d == S_EXPIRED) begin
      if (state_q != S_EXPIRED) begin
        blank_d = 1'b1;
      end else if (bcnt_q == B_TOP) begin
        blank_d = ~blank_q;
      end else begin
        blank_d = blank_q;
        bcnt_d  = bcnt_q + BW'(1);
      end
    end
  end

  // Blink registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      blank_q <= blank_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = 1'b0;
`endif

endmodule

// File: tb/tb_service_2_countdown.sv
// Directed bench for service_2_countdown, TICK_DIV=4,
// BLINK_DIV=2, queued expectations checked per cycle.
module tb_service_2_countdown;

`ifdef SERVICE2_BLINK_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  service_2_countdown_if bif ();

  service_2_countdown #(
    .TICK_DIV (4),
    .BLINK_DIV(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] t;
    logic        r;
    logic        a;
    logic        b;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t me;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(
    input int dc, input logic [15:0] t,
    input logic r, input logic a, input logic b,
    input string name
  );
    exp_t e;
    e.cyc  = cyc + dc;
    e.t    = t;
    e.r    = r;
    e.a    = a;
    e.b    = b & BE;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic load(
    input logic [15:0] n, input logic [15:0] t,
    input string name
  );
    bif.num = n;
    bif.finish1 = 1'b1;
    expect_at(1, t, 1'b0, 1'b0, 1'b0, name);
    step(1);
    bif.finish1 = 1'b0;
  endtask

  task automatic pulse();
    bif.push_c = 1'b1;
    step(1);
    bif.push_c = 1'b0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      me = q.pop_front();
      total++;
      if (me.cyc != cyc ||
          bif.time_out !== me.t ||
          bif.running !== me.r ||
          bif.alarm !== me.a ||
          bif.blank !== me.b) begin
        bad++;
        $display(
          "FAIL %s cyc=%0d got t=%h r=%b a=%b b=%b want t=%h r=%b a=%b b=%b",
          me.name, cyc, bif.time_out, bif.running,
          bif.alarm, bif.blank, me.t, me.r, me.a, me.b);
      end
    end
  end

  initial begin
    bif.finish1 = 1'b0;
    bif.num     = 16'h0000;
    bif.push_c  = 1'b0;
    step(2);
    expect_at(0, 16'h0000, 0, 0, 0, "reset_vals");
    step(1);
    reset = 1'b1;
    step(1);

    load(16'h0102, 16'h0102, "load_0102");
    step(3);
    expect_at(0, 16'h0102, 0, 0, 0, "loaded_hold");
    step(1);

    load(16'h1000, 16'h1000, "load_1000");
    expect_at(1, 16'h1000, 1, 0, 0, "run_on");
    expect_at(4, 16'h1000, 1, 0, 0, "pre_tick");
    expect_at(5, 16'h0959, 1, 0, 0, "borrow_0959");
    expect_at(41, 16'h0950, 1, 0, 0, "tick10");
    expect_at(2161, 16'h0100, 1, 0, 0, "at_0100");
    expect_at(2165, 16'h0059, 1, 0, 0, "borrow_0059");
    pulse();
    step(2164);

    load(16'h1287, 16'h1257, "clamp_1257");
    load(16'h0000, 16'h0000, "zero_load");
    expect_at(1, 16'h0000, 0, 0, 0, "zero_push");
    expect_at(5, 16'h0000, 0, 0, 0, "zero_idle");
    pulse();
    step(5);

    load(16'h0005, 16'h0005, "load_0005");
    expect_at(1, 16'h0005, 1, 0, 0, "p_start");
    pulse();
    step(1);
    expect_at(1, 16'h0005, 0, 0, 0, "paused");
    expect_at(20, 16'h0005, 0, 0, 0, "pause_hold");
    pulse();
    step(19);
    expect_at(1, 16'h0005, 1, 0, 0, "resume");
    expect_at(2, 16'h0005, 1, 0, 0, "resume_wait");
    expect_at(3, 16'h0004, 1, 0, 0, "resume_tick");
    expect_at(7, 16'h0003, 1, 0, 0, "tick_after");
    pulse();
    step(7);

    load(16'h0002, 16'h0002, "load_0002");
    expect_at(1, 16'h0002, 1, 0, 0, "e_run");
    expect_at(5, 16'h0001, 1, 0, 0, "e_0001");
    expect_at(8, 16'h0001, 1, 0, 0, "e_pre");
    expect_at(9, 16'h0000, 0, 1, 1, "expire");
    expect_at(10, 16'h0000, 0, 1, 1, "blink1");
    expect_at(11, 16'h0000, 0, 1, 0, "blink2");
    expect_at(12, 16'h0000, 0, 1, 0, "blink3");
    expect_at(13, 16'h0000, 0, 1, 1, "blink4");
    pulse();
    step(12);
    expect_at(1, 16'h0000, 0, 0, 0, "ack");
    pulse();
    step(1);

    load(16'h0200, 16'h0200, "load_0200");
    expect_at(1, 16'h0200, 1, 0, 0, "s6_run");
    expect_at(5, 16'h0159, 1, 0, 0, "s6_0159");
    pulse();
    step(6);
    bif.num = 16'h0030;
    bif.finish1 = 1'b1;
    bif.push_c = 1'b1;
    expect_at(1, 16'h0030, 0, 0, 0, "prio_load");
    expect_at(6, 16'h0030, 0, 0, 0, "prio_hold");
    step(1);
    bif.finish1 = 1'b0;
    bif.push_c = 1'b0;
    step(6);
    expect_at(1, 16'h0030, 1, 0, 0, "restart");
    pulse();
    step(2);
    expect_at(0, 16'h0000, 0, 0, 0, "async_reset");
    reset = 1'b0;
    #1;
    total++;
    if (bif.time_out !== 16'h0000 ||
        bif.running !== 1'b0 ||
        bif.alarm !== 1'b0 ||
        bif.blank !== 1'b0) begin
      bad++;
      $display("FAIL async_now got t=%h r=%b a=%b b=%b",
               bif.time_out, bif.running,
               bif.alarm, bif.blank);
    end
    step(1);
    expect_at(0, 16'h0000, 0, 0, 0, "in_reset");
    step(1);
    reset = 1'b1;
    step(3);

    while (q.size() > 0) begin
      me = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s never checked (due cyc=%0d)",
               me.name, me.cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
